// File: rtl/fetch_unit.sv
// Instruction fetch stage: keeps the fetch PC, issues one word read at a time
// to instruction memory and buffers {pc, instr} pairs for decode.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no request outstanding; waiting for a free queue slot
// REQ    | imem_req high, imem_addr held until imem_gnt
// WAIT   | request granted; waiting for imem_rvalid
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [CW-1:0] QD       = CW'(QDEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(QDEPTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [31:0]   fetch_pc;
    logic [31:0]   fetch_pc_nxt;
    logic [31:0]   req_pc;
    logic [31:0]   req_pc_nxt;
    logic          kill;
    logic          kill_nxt;

    logic [31:0]   q_instr [QDEPTH];
    logic [31:0]   q_pc    [QDEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;

    logic          rsp_done;
    logic          push;
    logic          pop;
    logic          slot_free;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // A response arriving with kill set, or alongside a redirect, is dropped.
    always_comb begin
        rsp_done = (state == S_WAIT) && imem_rvalid;
        push     = rsp_done && !kill && !redirect;
        pop      = dec_valid && dec_ready && !redirect;

        if (redirect) begin
            count_nxt = '0;
        end else begin
            count_nxt = count + CW'(push) - CW'(pop);
        end
        slot_free = (count_nxt < QD);

        fetch_pc_nxt = fetch_pc;
        if (redirect) begin
            fetch_pc_nxt = {redirect_pc[31:2], 2'b00};
        end else if (push) begin
            fetch_pc_nxt = fetch_pc + 32'd4;
        end
    end

    // A redirect never withdraws an issued or pending request; kill marks its
    // response for disposal instead.
    always_comb begin
        kill_nxt = kill;
        if (rsp_done) begin
            kill_nxt = 1'b0;
        end else if (redirect && ((state == S_REQ) || (state == S_WAIT))) begin
            kill_nxt = 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_pc_nxt = req_pc;
        case (state)
            S_IDLE: begin
                if (slot_free) begin
                    state_nxt  = S_REQ;
                    req_pc_nxt = fetch_pc_nxt;
                end
            end
            S_REQ: begin
                if (imem_gnt) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rsp_done) begin
                    if (slot_free) begin
                        state_nxt  = S_REQ;
                        req_pc_nxt = fetch_pc_nxt;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            kill     <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            req_pc   <= req_pc_nxt;
            kill     <= kill_nxt;
            count    <= count_nxt;
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= ptr_inc(wr_ptr);
                end
                if (pop) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
            end
        end
    end

    // Queue storage carries no reset; empty entries are masked at the outputs.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            q_instr[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]    <= req_pc;
        end
    end

    always_comb begin
        imem_req  = (state == S_REQ);
        imem_addr = req_pc;
        dec_valid = (count != '0);
        dec_instr = dec_valid ? q_instr[rd_ptr] : 32'd0;
        dec_pc    = dec_valid ? q_pc[rd_ptr]    : 32'd0;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a one-outstanding memory model returns ~addr
// as the instruction word; requests and decode pops are logged for checking.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;

    int n_cmp = 0;
    int n_err = 0;

    int          rv_lat;
    logic        pend;
    logic [31:0] pend_addr;
    int          dly_cnt;

    logic [31:0] req_log[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_instr[$];

    fetch_unit #(
        .RESET_PC(32'hBFC0_0000),
        .QDEPTH  (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .dec_instr  (dec_instr),
        .dec_pc     (dec_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory: immediate grant, rvalid rv_lat cycles later, data = ~addr.
    initial begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        pend        = 1'b0;
        pend_addr   = 32'd0;
        dly_cnt     = 0;
        forever begin
            @(negedge clk);
            imem_rvalid = 1'b0;
            imem_gnt    = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    if (dly_cnt <= 1) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = ~pend_addr;
                        pend        = 1'b0;
                    end else begin
                        dly_cnt = dly_cnt - 1;
                    end
                end
                if (imem_req && !pend) begin
                    imem_gnt  = 1'b1;
                    pend      = 1'b1;
                    pend_addr = imem_addr;
                    dly_cnt   = rv_lat;
                end
            end
        end
    end

    // Log accepted requests and decode pops just before each rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (rst_n) begin
                if (imem_req && imem_gnt) begin
                    req_log.push_back(imem_addr);
                end
                if (dec_valid && dec_ready && !redirect) begin
                    pop_pc.push_back(dec_pc);
                    pop_instr.push_back(dec_instr);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        step();
        rst_n    = 1'b0;
        redirect = 1'b0;
        step(3);
        req_log.delete();
        pop_pc.delete();
        pop_instr.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        dec_ready   = 1'b1;
        rv_lat      = 1;

        // reset state and sequential fetch
        step(3);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, dec_valid}, 32'd0);
        chk("rst_instr", dec_instr, 32'd0);
        chk("rst_pc", dec_pc, 32'd0);
        do_reset();
        step();
        chk("seq_req_a", {31'd0, imem_req}, 32'd1);
        chk("seq_addr_a", imem_addr, 32'hBFC0_0000);
        step();
        chk("seq_req_b", {31'd0, imem_req}, 32'd0);
        chk("seq_valid_b", {31'd0, dec_valid}, 32'd0);
        step();
        chk("seq_valid_c", {31'd0, dec_valid}, 32'd1);
        chk("seq_pc_c", dec_pc, 32'hBFC0_0000);
        chk("seq_instr_c", dec_instr, 32'h403F_FFFF);
        chk("seq_addr_c", imem_addr, 32'hBFC0_0004);
        step(8);
        chk("seq_req0", req_log[0], 32'hBFC0_0000);
        chk("seq_req1", req_log[1], 32'hBFC0_0004);
        chk("seq_req2", req_log[2], 32'hBFC0_0008);
        chk("seq_pop0", pop_pc[0], 32'hBFC0_0000);
        chk("seq_pop1", pop_pc[1], 32'hBFC0_0004);
        chk("seq_pop2", pop_pc[2], 32'hBFC0_0008);
        chk("seq_ins1", pop_instr[1], 32'h403F_FFFB);
        chk("seq_ins2", pop_instr[2], 32'h403F_FFF7);

        // backpressure: two entries fill, fetch stalls, then drains in order
        dec_ready = 1'b0;
        do_reset();
        step(10);
        chk("bp_req_idle", {31'd0, imem_req}, 32'd0);
        chk("bp_nreq", 32'(req_log.size()), 32'd2);
        chk("bp_npop", 32'(pop_pc.size()), 32'd0);
        chk("bp_valid", {31'd0, dec_valid}, 32'd1);
        chk("bp_head", dec_pc, 32'hBFC0_0000);
        dec_ready = 1'b1;
        step(14);
        chk("bp_pop0", pop_pc[0], 32'hBFC0_0000);
        chk("bp_pop1", pop_pc[1], 32'hBFC0_0004);
        chk("bp_pop2", pop_pc[2], 32'hBFC0_0008);
        chk("bp_pop3", pop_pc[3], 32'hBFC0_000C);
        chk("bp_ins3", pop_instr[3], 32'h403F_FFF3);
        chk("bp_req2", req_log[2], 32'hBFC0_0008);
        chk("bp_req3", req_log[3], 32'hBFC0_000C);

        // redirect while the response is still in flight
        rv_lat = 3;
        do_reset();
        step(2);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_1000;
        rv_lat      = 1;
        step();
        redirect = 1'b0;
        chk("rdw_valid", {31'd0, dec_valid}, 32'd0);
        chk("rdw_req_hold", {31'd0, imem_req}, 32'd0);
        step(2);
        chk("rdw_req", {31'd0, imem_req}, 32'd1);
        chk("rdw_addr", imem_addr, 32'h0000_1000);
        step(6);
        chk("rdw_nreq0", req_log[0], 32'hBFC0_0000);
        chk("rdw_nreq1", req_log[1], 32'h0000_1000);
        chk("rdw_pop0", pop_pc[0], 32'h0000_1000);
        chk("rdw_ins0", pop_instr[0], 32'hFFFF_EFFF);

        // redirect coincident with rvalid and a pop
        rv_lat    = 1;
        dec_ready = 1'b0;
        do_reset();
        step(4);
        chk("rdv_rvalid", {31'd0, imem_rvalid}, 32'd1);
        chk("rdv_valid_pre", {31'd0, dec_valid}, 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_2000;
        dec_ready   = 1'b1;
        step();
        redirect = 1'b0;
        chk("rdv_valid", {31'd0, dec_valid}, 32'd0);
        chk("rdv_req", {31'd0, imem_req}, 32'd1);
        chk("rdv_addr", imem_addr, 32'h0000_2000);
        step(4);
        chk("rdv_npop", 32'(pop_pc.size()), 32'd1);
        chk("rdv_pop0", pop_pc[0], 32'h0000_2000);

        // misaligned target and address wrap
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        step();
        redirect = 1'b0;
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        step(8);
        chk("wrap_req1", req_log[1], 32'h0000_0000);
        chk("wrap_pop0", pop_pc[0], 32'hFFFF_FFFC);
        chk("wrap_pop1", pop_pc[1], 32'h0000_0000);
        chk("wrap_ins1", pop_instr[1], 32'hFFFF_FFFF);

        // reset during WAIT with a queued entry
        rv_lat    = 1;
        dec_ready = 1'b0;
        do_reset();
        step(2);
        rv_lat = 3;
        step(2);
        chk("mrst_valid_pre", {31'd0, dec_valid}, 32'd1);
        rst_n = 1'b0;
        step();
        chk("mrst_valid", {31'd0, dec_valid}, 32'd0);
        chk("mrst_req", {31'd0, imem_req}, 32'd0);
        chk("mrst_pc", dec_pc, 32'd0);
        req_log.delete();
        rv_lat = 1;
        rst_n  = 1'b1;
        step();
        chk("mrst_req_after", {31'd0, imem_req}, 32'd1);
        chk("mrst_addr_after", imem_addr, 32'hBFC0_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
